alu_mul_sequencer: RTL and testbench

Multi-cycle sequencer that computes the low 32 bits of an unsigned 32x32 multiply using the shared 32-bit ALU. It issues one ALU add per multiplier bit. It sits beside the execute-stage ALU and owns the ALU operand and control inputs only while a multiply is in flight. Requests and results use valid/ready handshakes, so the pipeline control can stall around it.

---
 rtl/alu_mul_sequencer_if.sv | 39 +++
 rtl/alu_mul_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// ============================================================================
// Module  : alu_mul_sequencer_if
// Purpose : Request/response handshake and shared-ALU port bundle for the
//           multi-cycle multiply sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_mul_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        busy;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;

  // Sequencer side
  modport slave (
    input  req_valid, req_a, req_b, resp_ready, alu_result,
    output req_ready, resp_valid, resp_result, resp_zero, busy,
           alu_a, alu_b, alu_ctrl
  );

  // Pipeline control / ALU side
  modport master (
    output req_valid, req_a, req_b, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_result, resp_zero, busy,
           alu_a, alu_b, alu_ctrl
  );
endinterface

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module  : alu_mul_sequencer
// Purpose : Shift-and-add 32x32 unsigned multiply (low word) that borrows the
//           shared execute-stage ALU for one add per multiplier bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_sequencer #(
  parameter logic [2:0] ADD_CODE   = 3'b010,
  parameter int         EARLY_EXIT = 1
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  alu_mul_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        w_mplier_exhausted;
  logic        w_last_iter;
  logic        w_in_calc;
  logic        w_in_done;

  // Early exit looks at the bits that remain after this iteration's bit 0.
  generate
    if (EARLY_EXIT != 0) begin : g_early_exit
      assign w_mplier_exhausted = (mplier_q[31:1] == 31'd0);
    end else begin : g_full_iter
      assign w_mplier_exhausted = 1'b0;
    end
  endgenerate

  assign w_last_iter = (cnt_q == 5'd31) || w_mplier_exhausted;
  assign w_in_calc   = (state_q == ST_CALC);
  assign w_in_done   = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          mcand_d  = bus.req_a;
          mplier_d = bus.req_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end

      ST_CALC: begin
        // Wrapping add is exact for the low word, so no carry is kept.
        if (mplier_q[0]) begin
          acc_d = bus.alu_result;
        end
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (w_last_iter) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.resp_valid  = w_in_done;
  assign bus.busy        = w_in_calc || w_in_done;
  assign bus.resp_result = w_in_done ? acc_q : 32'd0;
  assign bus.resp_zero   = (bus.resp_result == 32'd0);

  // Operands are zeroed outside CALC so the shared ALU output is predictable.
  assign bus.alu_a       = w_in_calc ? acc_q   : 32'd0;
  assign bus.alu_b       = w_in_calc ? mcand_q : 32'd0;
  assign bus.alu_ctrl    = ADD_CODE;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ============================================================================
// Module  : tb_alu_mul_sequencer
// Purpose : Directed, table-driven self-checking bench for alu_mul_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_sequencer;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  alu_mul_sequencer_if bus_ee ();
  alu_mul_sequencer_if bus_full ();

  // External ALU model: plain wrapping add.
  assign bus_ee.alu_result   = bus_ee.alu_a + bus_ee.alu_b;
  assign bus_full.alu_result = bus_full.alu_a + bus_full.alu_b;

  alu_mul_sequencer #(.ADD_CODE(3'b010), .EARLY_EXIT(1)) dut_ee (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ee)
  );

  alu_mul_sequencer #(.ADD_CODE(3'b010), .EARLY_EXIT(0)) dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    int          k;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One request on the early-exit instance with resp_ready held high.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int k);
    int n;
    @(negedge clk);
    bus_ee.req_a     = a;
    bus_ee.req_b     = b;
    bus_ee.req_valid = 1'b1;
    chk("req_ready_before_accept", {31'd0, bus_ee.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus_ee.req_valid = 1'b0;
    chk("busy_after_accept", {31'd0, bus_ee.busy}, 32'd1);
    n = 0;
    while (!bus_ee.resp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus_ee.resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_valid_timeout actual=0 required=1");
    end
    k   = n;
    res = bus_ee.resp_result;
    z   = bus_ee.resp_zero;
    @(posedge clk);
    #1;
    chk("idle_after_resp_ready", {30'd0, bus_ee.req_ready, bus_ee.resp_valid}, 32'd2);
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          k;
    logic [31:0] e_acc;
    logic [31:0] e_mc;
    logic [31:0] e_mp;
    int          n;

    checks = 0;
    errors = 0;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          res: 32'd15,         zero: 1'b0, k: 3};
    vecs[1] = '{a: 32'd1234,       b: 32'd0,          res: 32'd0,          zero: 1'b1, k: 1};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  res: 32'd1,          zero: 1'b0, k: 32};
    vecs[3] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  res: 32'd0,          zero: 1'b1, k: 17};
    vecs[4] = '{a: 32'd7,          b: 32'd6,          res: 32'd42,         zero: 1'b0, k: 3};
    vecs[5] = '{a: 32'h1234_5678,  b: 32'd1,          res: 32'h1234_5678,  zero: 1'b0, k: 1};
    vecs[6] = '{a: 32'hFFFF_FFFF,  b: 32'd3,          res: 32'hFFFF_FFFD,  zero: 1'b0, k: 2};
    vecs[7] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  res: 32'd0,          zero: 1'b1, k: 32};
    vecs[8] = '{a: 32'd100,        b: 32'h8000_0001,  res: 32'd100,        zero: 1'b0, k: 32};

    rst_n = 1'b0;
    bus_ee.req_valid   = 1'b0;
    bus_ee.req_a       = '0;
    bus_ee.req_b       = '0;
    bus_ee.resp_ready  = 1'b1;
    bus_full.req_valid = 1'b0;
    bus_full.req_a     = '0;
    bus_full.req_b     = '0;
    bus_full.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",   {31'd0, bus_ee.req_ready},  32'd1);
    chk("rst_resp_valid",  {31'd0, bus_ee.resp_valid}, 32'd0);
    chk("rst_busy",        {31'd0, bus_ee.busy},       32'd0);
    chk("rst_alu_a",       bus_ee.alu_a,               32'd0);
    chk("rst_alu_b",       bus_ee.alu_b,               32'd0);
    chk("rst_alu_ctrl",    {29'd0, bus_ee.alu_ctrl},   32'd2);
    chk("rst_resp_zero",   {31'd0, bus_ee.resp_zero},  32'd1);
    chk("rst_resp_result", bus_ee.resp_result,         32'd0);
    chk("rst_full_req_ready", {31'd0, bus_full.req_ready}, 32'd1);
    chk("rst_full_alu_ctrl",  {29'd0, bus_full.alu_ctrl},  32'd2);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, res, z, k);
      chk($sformatf("vec%0d_result", i), res, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].zero});
      chk($sformatf("vec%0d_cycles", i), k, vecs[i].k);
    end

    // Backpressure: hold the 7*6 response and try to sneak in a request.
    bus_ee.resp_ready = 1'b0;
    @(negedge clk);
    bus_ee.req_a     = 32'd7;
    bus_ee.req_b     = 32'd6;
    bus_ee.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_ee.req_valid = 1'b0;
    n = 0;
    while (!bus_ee.resp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_cycles", n, 32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        @(negedge clk);
        bus_ee.req_a     = 32'd11;
        bus_ee.req_b     = 32'd13;
        bus_ee.req_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus_ee.req_valid = 1'b0;
      chk($sformatf("bp_hold_result%0d", i), bus_ee.resp_result, 32'd42);
      chk($sformatf("bp_hold_ready%0d", i),
          {30'd0, bus_ee.req_ready, bus_ee.resp_valid}, 32'd1);
    end
    @(negedge clk);
    bus_ee.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle",
        {29'd0, bus_ee.req_ready, bus_ee.resp_valid, bus_ee.busy}, 32'd4);
    do_op(32'd9, 32'd9, res, z, k);
    chk("bp_next_result", res, 32'd81);
    chk("bp_next_cycles", k, 32'd4);

    // Full-iteration instance: trace operands through all 32 CALC cycles.
    @(negedge clk);
    bus_full.req_a     = 32'd3;
    bus_full.req_b     = 32'd5;
    bus_full.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_full.req_valid = 1'b0;
    e_acc = 32'd0;
    e_mc  = 32'd3;
    e_mp  = 32'd5;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("full_alu_a_c%0d", i), bus_full.alu_a, e_acc);
      chk($sformatf("full_alu_b_c%0d", i), bus_full.alu_b, e_mc);
      chk($sformatf("full_no_resp_c%0d", i), {31'd0, bus_full.resp_valid}, 32'd0);
      if (e_mp[0]) e_acc = e_acc + e_mc;
      e_mc = e_mc << 1;
      e_mp = e_mp >> 1;
      @(posedge clk);
      #1;
    end
    chk("full_resp_valid", {31'd0, bus_full.resp_valid}, 32'd1);
    chk("full_result", bus_full.resp_result, 32'd15);
    chk("full_done_alu_a", bus_full.alu_a, 32'd0);
    @(posedge clk);
    #1;
    chk("full_back_idle", {31'd0, bus_full.req_ready}, 32'd1);

    // Mid-operation asynchronous reset on the 10th CALC cycle.
    @(negedge clk);
    bus_ee.req_a     = 32'h1234_5678;
    bus_ee.req_b     = 32'h9ABC_DEF1;
    bus_ee.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_ee.req_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_busy_before", {31'd0, bus_ee.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready",  {31'd0, bus_ee.req_ready},  32'd1);
    chk("midrst_resp_valid", {31'd0, bus_ee.resp_valid}, 32'd0);
    chk("midrst_busy",       {31'd0, bus_ee.busy},       32'd0);
    chk("midrst_alu_a",      bus_ee.alu_a,               32'd0);
    chk("midrst_alu_b",      bus_ee.alu_b,               32'd0);
    chk("midrst_resp_zero",  {31'd0, bus_ee.resp_zero},  32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_hold_resp%0d", i), {31'd0, bus_ee.resp_valid}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_no_resp", {31'd0, bus_ee.resp_valid}, 32'd0);
    do_op(32'd2, 32'd2, res, z, k);
    chk("postrst_result", res, 32'd4);
    chk("postrst_cycles", k, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
